// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: N-CPU MSI snoop arbiter funnelling I/D cache requests onto one RAM port
// Ports: CLK/RST (sync, active-high); iREN/dREN/dWEN/cctrans/ccwrite per-CPU strobes;
//   iaddr/daddr/dstore per-CPU words at [i*WORD_W +: WORD_W]; iwait/dwait/iload/dload per-CPU replies;
//   ccwait/ccinv/ccsnoopaddr snoop outputs to each cache; ram* RAM port; ram_err sticky RAM error flag.
module coherence_bus_arbiter #(
  parameter int CPUS      = 2,
  parameter int WORD_W    = 32,
  parameter int SNOOP_CYC = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0]          cctrans,
  input  logic [CPUS-1:0]          ccwrite,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic                     ram_err
);
  localparam int IW = $clog2(CPUS);
  localparam int CW = $clog2(SNOOP_CYC) + 1;
  typedef enum logic [2:0] {IDLE, SNOOP, XFER, RAMD, RAMI} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] dptr_q, dptr_d, iptr_q, iptr_d, g_q, g_d;
  logic ccw_q, ccw_d, ram_err_q, ram_err_d;
  logic [WORD_W-1:0] ccsnoopaddr_q [CPUS];
  logic [WORD_W-1:0] ccsnoopaddr_d [CPUS];
  logic [WORD_W-1:0] iaddr_a [CPUS];
  logic [WORD_W-1:0] daddr_a [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];
  logic [WORD_W-1:0] iload_a [CPUS];
  logic [WORD_W-1:0] dload_a [CPUS];
  logic [CPUS-1:0] dreq;
  logic [IW-1:0] dg, ig, s;
  logic has_s, acc, err;
  for (genvar i = 0; i < CPUS; i++) begin : g_pack
    assign iaddr_a[i]                      = iaddr[i*WORD_W +: WORD_W];
    assign daddr_a[i]                      = daddr[i*WORD_W +: WORD_W];
    assign dstore_a[i]                     = dstore[i*WORD_W +: WORD_W];
    assign iload[i*WORD_W +: WORD_W]       = iload_a[i];
    assign dload[i*WORD_W +: WORD_W]       = dload_a[i];
    assign ccsnoopaddr[i*WORD_W +: WORD_W] = ccsnoopaddr_q[i];
  end
  // First requester at or after ptr, wrapping; lowest offset wins.
  function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] r;
    r = ptr;
    for (int k = CPUS-1; k >= 0; k--)
      if (req[(int'(ptr)+k) % CPUS]) r = IW'((int'(ptr)+k) % CPUS);
    return r;
  endfunction
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return IW'((int'(x)+1) % CPUS);
  endfunction
  assign ram_err = ram_err_q;
  always_comb begin
    dreq = dREN | dWEN | (cctrans & ccwrite);
    dg = rr_pick(dreq, dptr_q);
    ig = rr_pick(iREN, iptr_q);
    acc = ramstate == 2'd2;
    err = ramstate == 2'd3;
    has_s = 1'b0;
    s = '0;
    // Lowest-numbered other cache holding a dirty line it is writing back.
    for (int j = CPUS-1; j >= 0; j--)
      if (dWEN[j] && IW'(j) != g_q) begin
        has_s = 1'b1;
        s = IW'(j);
      end
    state_d = state_q;
    cnt_d = cnt_q;
    dptr_d = dptr_q;
    iptr_d = iptr_q;
    g_d = g_q;
    ccw_d = ccw_q;
    ccsnoopaddr_d = ccsnoopaddr_q;
    ram_err_d = ram_err_q | (err && state_q != IDLE);
    iwait = '1;
    dwait = '1;
    ccwait = '0;
    ccinv = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    for (int j = 0; j < CPUS; j++) begin
      iload_a[j] = '0;
      dload_a[j] = '0;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|dreq) begin
          g_d = dg;
          dptr_d = inc(dg);
          ccw_d = ccwrite[dg];
          state_d = cctrans[dg] ? SNOOP : RAMD;
        end else if (|iREN) begin
          g_d = ig;
          iptr_d = inc(ig);
          state_d = RAMI;
        end
      end
      SNOOP: begin
        for (int j = 0; j < CPUS; j++)
          if (IW'(j) != g_q) begin
            ccwait[j] = 1'b1;
            ccinv[j] = ccw_q;
            ccsnoopaddr_d[j] = daddr_a[g_q];
          end
        if (!err) begin
          cnt_d = cnt_q + 1'b1;
          state_d = cnt_q == CW'(SNOOP_CYC-1) ? XFER : SNOOP;
        end
      end
      XFER: begin
        for (int j = 0; j < CPUS; j++)
          if (IW'(j) != g_q) begin
            ccwait[j] = 1'b1;
            ccinv[j] = ccw_q;
          end
        if (has_s) begin
          ramWEN = 1'b1;
          ramaddr = daddr_a[s];
          ramstore = dstore_a[s];
          dload_a[g_q] = dstore_a[s];
          if (acc) begin
            dwait[s] = 1'b0;
            dwait[g_q] = ~dREN[g_q];
          end
        end else if (!err)
          state_d = (dREN[g_q] | dWEN[g_q]) ? RAMD : IDLE;
      end
      RAMD: begin
        ramaddr = daddr_a[g_q];
        if (dREN[g_q]) begin
          ramREN = 1'b1;
          dload_a[g_q] = ramload;
        end else if (dWEN[g_q]) begin
          ramWEN = 1'b1;
          ramstore = dstore_a[g_q];
        end
        dwait[g_q] = ~(acc && (dREN[g_q] | dWEN[g_q]));
        if (!err && !(dREN[g_q] | dWEN[g_q])) state_d = IDLE;
      end
      RAMI: begin
        ramREN = 1'b1;
        ramaddr = iaddr_a[g_q];
        iload_a[g_q] = ramload;
        iwait[g_q] = ~acc;
        if (!err && !iREN[g_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dptr_q <= '0;
      iptr_q <= '0;
      g_q <= '0;
      ccw_q <= 1'b0;
      ram_err_q <= 1'b0;
      for (int j = 0; j < CPUS; j++) ccsnoopaddr_q[j] <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dptr_q <= dptr_d;
      iptr_q <= iptr_d;
      g_q <= g_d;
      ccw_q <= ccw_d;
      ram_err_q <= ram_err_d;
      ccsnoopaddr_q <= ccsnoopaddr_d;
    end
  end
endmodule
